tinyml_issue_sequencer: RTL

- Program sequencer for the tinyml RISC core: fetches 16-bit instructions from instruction memory over a req/valid handshake and issues one decoded instruction at a time to the decode/execute datapath.
- Stalls issue for the fixed execution latency of multi-cycle ops (mac4, conv3x3), so the register file and the control decode always see exactly one instruction in flight.
- Stops on HALT; software restarts it with start.

---
 rtl/tinyml_issue_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tinyml_issue_sequencer.sv
// tinyml_issue_sequencer: fetches 16-bit instructions over a req/valid
// handshake and issues them one at a time, stalling for the fixed latency
// of multi-cycle ops (mac4, conv3x3) so only one instruction is in flight.
// Optional build macro: TINYML_SEQ_ILLEGAL_TRAP_EN -- reserved opcodes stop
// the sequencer and set a sticky illegal flag instead of issuing as NOPs.
module tinyml_issue_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int MAC_LAT  = 4,
    parameter int CONV_LAT = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_valid,
    input  logic [15:0]       instr_data,
    output logic              issue_valid,
    output logic [3:0]        issue_opcode,
    output logic [3:0]        issue_rd,
    output logic [3:0]        issue_rs1,
    output logic [3:0]        issue_rs2,
    output logic [7:0]        issue_imm8,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       retired
);

    localparam logic [3:0] OP_MAC  = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1100;
    localparam logic [3:0] OP_CONV = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] instr_q;
    logic [3:0]  wait_cnt;
    logic [3:0]  lat_sel;
    logic        handshake;
    logic        is_halt;
    logic        trap;

    assign handshake = instr_req & instr_valid;
    assign is_halt   = (instr_data[15:12] == OP_HALT);

`ifdef TINYML_SEQ_ILLEGAL_TRAP_EN
    logic is_reserved;
    assign is_reserved = (instr_data[15:12] == 4'b0111) ||
                         (instr_data[15:12] == 4'b1001) ||
                         (instr_data[15:12] == 4'b1010) ||
                         (instr_data[15:12] == 4'b1011);
    assign trap = is_reserved;

    // Sticky trap flag: set by a reserved fetch, cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if (!abort) begin
            if (state == S_IDLE && start)
                illegal <= 1'b0;
            else if (state == S_FETCH && handshake && !is_halt && trap)
                illegal <= 1'b1;
        end
    end
`else
    assign trap    = 1'b0;
    assign illegal = 1'b0;
`endif

    // Execute latency of the latched instruction; single-cycle ops use 1
    always_comb begin
        lat_sel = 4'd1;
        case (instr_q[15:12])
            OP_MAC:  lat_sel = 4'(MAC_LAT);
            OP_CONV: lat_sel = 4'(CONV_LAT);
            default: lat_sel = 4'd1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and strobes; abort overrides everything and kills done/issue
    always_comb begin
        state_nxt   = state;
        instr_req   = 1'b0;
        issue_valid = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                instr_req = 1'b1;
                if (handshake) begin
                    if (is_halt) begin
                        state_nxt = S_IDLE;
                        done      = 1'b1;
                    end else if (trap) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                issue_valid = 1'b1;
                state_nxt   = (lat_sel > 4'd1) ? S_WAIT : S_FETCH;
            end
            S_WAIT: begin
                if (wait_cnt <= 4'd1) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt   = S_IDLE;
            issue_valid = 1'b0;
            done        = 1'b0;
        end
    end

    // PC, retire count, instruction latch and stall counter; abort freezes all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            retired  <= '0;
            instr_q  <= '0;
            wait_cnt <= '0;
        end else if (!abort) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc      <= start_addr;
                        retired <= '0;
                    end
                end
                S_FETCH: begin
                    // HALT and trapped opcodes leave the issue fields untouched
                    if (handshake && !is_halt && !trap) instr_q <= instr_data;
                end
                S_ISSUE: begin
                    retired  <= retired + 16'd1;
                    pc       <= pc + 1'b1;
                    wait_cnt <= lat_sel - 4'd1;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign instr_addr   = pc;
    assign busy         = (state != S_IDLE);
    assign issue_opcode = instr_q[15:12];
    assign issue_rd     = instr_q[11:8];
    assign issue_rs1    = instr_q[7:4];
    assign issue_rs2    = instr_q[3:0];
    assign issue_imm8   = instr_q[7:0];

endmodule
